// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad by driving one row low at a time
// and reading the active-low columns. A press is reported once, after it has
// been stable for DEBOUNCE_SCANS row samples. A new key is reported only after
// the release of the previous one has been debounced.
//
// Output protocol: key_valid_o is a one-cycle strobe with no ready/backpressure.
// key_o is valid in the strobe cycle and keeps that value until the next
// accepted key. key_held_o is high from the strobe cycle until the release
// has been debounced.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic [1:0] state_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       col_meta, col_s;
  logic [DIV_W-1:0] div_q;
  logic             sample;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       key_row_q, key_row_d;
  logic [1:0]       key_col_q, key_col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             strobe_d;
  logic             single_hit;
  logic [1:0]       hit_col;
  logic [3:0]       latched_pat;
  logic [3:0]       key_q;
  logic             valid_q;

  // Keypad legend for row r, column c; the bottom row carries * (E) and # (F).
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser for the asynchronous column inputs (idle = all high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col_i;
      col_s    <= col_meta;
    end
  end

  // Row period divider; the last count of each period is the sample point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign sample      = (div_q == DIV_LAST);
  assign latched_pat = ~(4'b0001 << key_col_q);
  assign cnt_inc     = (cnt_q == CNT_TARGET) ? cnt_q : cnt_q + CNT_W'(1);

  // Decode the column sample: only a single low column is a usable key.
  always_comb begin
    single_hit = 1'b1;
    hit_col    = 2'd0;
    case (col_s)
      4'b1110: hit_col = 2'd0;
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      4'b0111: hit_col = 2'd3;
      default: single_hit = 1'b0;
    endcase
  end

  // Next-state logic; every decision is taken only at the sample point.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    cnt_d     = cnt_q;
    strobe_d  = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (single_hit) begin
            key_row_d = row_idx_q;
            key_col_d = hit_col;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_s == latched_pat) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TARGET) begin
              // Release counting starts from zero once the key is held.
              state_d  = HELD;
              cnt_d    = '0;
              strobe_d = 1'b1;
            end
          end else begin
            state_d   = SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        HELD: begin
          if (col_s == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TARGET) begin
              state_d   = SCAN;
              cnt_d     = '0;
              row_idx_d = row_idx_q + 2'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // FSM, row pointer, latched key position and debounce counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SCAN;
      row_idx_q <= 2'd0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registered key code and strobe, both updated the cycle after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= strobe_d;
      if (strobe_d) begin
        key_q <= key_code(key_row_q, key_col_q);
      end
    end
  end

  assign row_o       = ~(4'b0001 << row_idx_q);
  assign key_o       = key_q;
  assign key_valid_o = valid_q;
  assign key_held_o  = (state_q == HELD);
  assign state_o     = state_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix hex keypad and reports one debounced key code per press, with a single-cycle valid strobe.
- Input-side counterpart of the multiplexed 7-segment display driver: the display drives anodes and outputs segments; this block drives rows and reads columns.
- Sits beside the button and switch conditioners and feeds operand digits to the calculator controller.

Parameters:
- SCAN_DIV, 1000: clk cycles per row period. Minimum 4, to allow for synchroniser latency plus settling.
- DEBOUNCE_SCANS, 8: consecutive matching samples needed to accept a press or a release. Minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- col_i  input  4  keypad columns; active-low, pulled up externally
- row_o  output  4  row drive; active-low, one-cold
- key_o  output  4  hex code of the last accepted key
- key_valid_o  output  1  one-cycle strobe; key_o is valid in the same cycle
- key_held_o  output  1  high while the accepted key is held (release not yet debounced)

Behaviour:
- Reset (rst=0, async): row_o=4'b1110, key_o=0, key_valid_o=0, key_held_o=0, state=SCAN, row index=0, divider=0, debounce count=0, synchroniser flops=4'hF.
- col_i passes through a 2-flop synchroniser; all decisions use the synchronised value (colS).
- Divider counts 0..SCAN_DIV-1 and wraps. The "sample point" is the cycle where divider==SCAN_DIV-1.
- row_o = ~(1<<row_idx).
- In SCAN, row_idx increments modulo 4 at each sample point: 0→1→2→3→0.
- State SCAN, at each sample point:
  - colS==4'hF, or colS with more than one zero (ghost/multi-key): advance row, stay in SCAN.
  - colS with exactly one zero: latch row_idx and the column index, clear count, go to DEBOUNCE. Row does not advance.
- State DEBOUNCE: row frozen. At each sample point:
  - colS equals the latched one-cold pattern: count++. When count reaches DEBOUNCE_SCANS, go to HELD; in the next cycle key_valid_o=1 for exactly one cycle, key_o=code, key_held_o=1.
  - Mismatch: go to SCAN, advance row, no strobe.
- State HELD: row frozen, key_held_o=1. At each sample point:
  - colS==4'hF: count++; otherwise count=0.
  - When count reaches DEBOUNCE_SCANS: key_held_o=0, go to SCAN and advance row.
  - key_o holds its value until the next accepted key.
- Other keys pressed while in HELD are ignored. No repeat and no second strobe until release is debounced.
- Code map (row r, col c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Latency: key_valid_o asserts 1 cycle after the DEBOUNCE_SCANS-th matching sample following the detection sample.
- Reset asserted mid-DEBOUNCE or mid-HELD: immediate return to reset values; no strobe is ever emitted for an interrupted press.
- Counters saturate; no wrap-around in count.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3. Keypad model: col_i[c]=0 iff row_o[r]==0 and key (r,c) is pressed.
1. Hold rst=0, then release -> outputs at reset values. row_o sequence 1110,1101,1011,0111,1110, changing every 4 cycles. key_valid_o stays 0 with no key pressed.
2. Press (r1,c2) and hold for 40 cycles, then release -> exactly one key_valid_o pulse with key_o=4'h6, 1+3 samples after detection. key_held_o=1 from the strobe until 3 released samples, then scanning resumes from row 2.
3. Press (r0,c0) for one sample only (bounce) -> no key_valid_o, key_held_o stays 0, scanning continues.
4. Press (r2,c0) and (r2,c1) together -> no strobe. Press (r0,c3) and (r3,c1) together -> key_o=4'hA only, one strobe.
5. Press (r3,c0), release, then press (r3,c1) -> strobes with key_o=4'hE, then 4'h0.
6. Pull rst=0 while in HELD on (r1,c1) -> row_o=1110 and key_held_o=0 immediately. After release of rst with the key still pressed, the key is re-detected with one fresh strobe, key_o=4'h5.
